cpu_step_controller: RTL
========================

// Module: cpu_step_controller
// PURPOSE
// - Sequences the ARM core for board-level debug: HALT, single-STEP (KEY), free-RUN (SW) and
//   BREAK on a selected decoded instruction type.
// - Sole source of the core clock-enable cpu_en. Consumes instr_type from the instruction-type
//   decoder that drives HEX4/HEX5, so PC/mnemonic displays stay readable.
// PARAMETERS
// - RUN_DIV     25_000_000  clk cycles between cpu_en pulses in RUN (50 MHz -> 2 instr/s); >=2
// - DEB_CYCLES  1_000_000   cycles key_step_n must be stable before accepted (20 ms); >=2
// - CNT_W       16          width of step_count
// PORTS
// - clk          in   1      system clock
// - rst_n        in   1      asynchronous active-low reset
// - key_step_n   in   1      raw push button, active-low, asynchronous
// - sw_run       in   1      raw slide switch, 1 = RUN, asynchronous
// - sw_bp_en     in   1      raw slide switch, 1 = breakpoint armed, asynchronous
// - bp_type      in   4      instruction type to break on (1..15; 0 never matches)
// - instr_type   in   4      decoded type of instruction at current PC (combinational, 0 = other)
// - pc           in   32     current PC
// - cpu_en       out  1      one-cycle core advance pulse
// - ctrl_state   out  2      0 HALT, 1 STEP, 2 RUN, 3 BREAK
// - bp_pc        out  32     PC latched on BREAK entry
// - step_count   out  CNT_W  number of cpu_en pulses issued, wraps to 0
// BEHAVIOUR
// - Clock and reset: one clock. Reset is asynchronous and active-low.
// - Reset values: state HALT, cpu_en 0, bp_pc 0, step_count 0, divider 0, debouncer idle (key released).
// - Input conditioning:
//   - sw_run, sw_bp_en, key_step_n each pass a 2-FF synchronizer.
//   - Synced key is debounced: state changes only after DEB_CYCLES consecutive equal samples.
//   - step_press = one-cycle pulse on debounced 1->0 transition. Release generates nothing.
// - FSM (registered; outputs from state/regs):
//   - HALT:
//     - sw_run=1 -> RUN, divider cleared.
//     - Else step_press -> STEP.
//     - sw_run has priority over step_press in the same cycle.
//   - STEP: cpu_en=1 for exactly this cycle. Next state is RUN if sw_run=1, else HALT.
//   - RUN:
//     - divider counts 0..RUN_DIV-1. The tick is the cycle where divider==RUN_DIV-1.
//     - On tick, if sw_bp_en=1 and instr_type==bp_type and bp_type!=0:
//       -> BREAK, bp_pc<=pc, no cpu_en pulse.
//     - On tick otherwise: cpu_en=1 that cycle, divider wraps to 0.
//     - sw_run=0 -> HALT, divider cleared. Takes priority over a same-cycle tick (no pulse).
//     - step_press ignored in RUN.
//   - BREAK:
//     - step_press -> STEP, which executes the matched instruction.
//     - sw_run=0 -> HALT. This has priority over a same-cycle step_press.
//     - bp_pc holds until the next BREAK entry.
// - Breakpoint checked only on RUN ticks. STEP never breaks, so stepping out of BREAK always advances.
// - cpu_en is never high on two consecutive cycles. Max one pulse per step_press.
// - step_count increments on every cycle cpu_en=1: 0xFFFF -> 0x0000.
// - Reset asserted mid-RUN/STEP: everything returns to reset values immediately, cpu_en drops asynchronously.
// - ctrl_state is the registered FSM state, so it is 1 exactly when cpu_en is from a step.
// STRUCTURE
// - cpu_ctrl_pkg:
//   - typedef enum logic[1:0] ctrl_state_t {ST_HALT, ST_STEP, ST_RUN, ST_BREAK}
//   - localparams ITYPE_OTHER=0, MOV=1, STR=2, LDR=3, ADD=4, SUB=5, AND=6, B=7, CMP=8,
//     MUL=9, ORR=10, EOR=11, MVN=12, STRB=13, LDRB=14, BX=15.
//     The decoder adopts these too.
// - One sub-module: button_debounce (2-FF sync + stability counter + falling-edge pulse),
//   parameter DEB_CYCLES. Switch synchronizers stay inline.
// TESTING (bench overrides RUN_DIV=4, DEB_CYCLES=3)
// - Reset:
//   - Stimulus: rst_n=0 for 2 cycles.
//   - Required: cpu_en=0, ctrl_state=0, step_count=0, bp_pc=0. Also hold rst_n low mid-RUN -> same values same cycle.
// - Single step:
//   - Stimulus: in HALT, key_step_n low for 10 cycles, then high.
//   - Required: exactly one cpu_en pulse, step_count=1, ctrl_state back to 0.
//   - Glitch 2-cycle low pulse -> no cpu_en.
// - Run rate:
//   - Stimulus: sw_run=1 for 40 cycles, instr_type=4, sw_bp_en=0.
//   - Required: cpu_en pulses exactly 4 cycles apart. step_count = number of pulses.
//   - Then sw_run=0 -> HALT, no further pulses.
// - Breakpoint:
//   - Stimulus: sw_bp_en=1, bp_type=7, RUN. instr_type=4 for first 2 ticks, then 7 with pc=0x2C.
//   - Required: 2 pulses, then ctrl_state=3, bp_pc=0x2C, cpu_en stays 0.
//   - Key press -> one pulse. Returns to RUN; the next tick with instr_type=4 pulses normally.
// - Priority/edges:
//   - bp_type=0 with instr_type=0 -> never breaks.
//   - sw_run falls on tick cycle -> no pulse, HALT.
//   - step_count at 0xFFFF + one step -> 0x0000.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_pkg : controller state encoding and decoded instruction-type codes
// Rev 1.0
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BREAK = 2'd3
  } ctrl_state_t;

  localparam logic [3:0] ITYPE_OTHER = 4'd0;
  localparam logic [3:0] ITYPE_MOV   = 4'd1;
  localparam logic [3:0] ITYPE_STR   = 4'd2;
  localparam logic [3:0] ITYPE_LDR   = 4'd3;
  localparam logic [3:0] ITYPE_ADD   = 4'd4;
  localparam logic [3:0] ITYPE_SUB   = 4'd5;
  localparam logic [3:0] ITYPE_AND   = 4'd6;
  localparam logic [3:0] ITYPE_B     = 4'd7;
  localparam logic [3:0] ITYPE_CMP   = 4'd8;
  localparam logic [3:0] ITYPE_MUL   = 4'd9;
  localparam logic [3:0] ITYPE_ORR   = 4'd10;
  localparam logic [3:0] ITYPE_EOR   = 4'd11;
  localparam logic [3:0] ITYPE_MVN   = 4'd12;
  localparam logic [3:0] ITYPE_STRB  = 4'd13;
  localparam logic [3:0] ITYPE_LDRB  = 4'd14;
  localparam logic [3:0] ITYPE_BX    = 4'd15;

  // "Other" is never a breakpoint target, so an unconfigured bp_type can't stall RUN.
  function automatic logic bp_hit(input logic armed, input logic [3:0] itype,
                                  input logic [3:0] bp);
    return armed && (bp != ITYPE_OTHER) && (itype == bp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// button_debounce : 2-FF synchronizer, stability filter, press (1->0) pulse
// Rev 1.0
// ============================================================================
module button_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int c_cnt_w = $clog2(DEB_CYCLES);

  logic               r_meta;
  logic               r_sync;
  logic               r_stable;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_meta  <= i_key_n;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_w'(DEB_CYCLES - 1)) begin
        r_cnt    <= '0;
        r_stable <= r_sync;
        r_press  <= ~r_sync;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// cpu_step_controller : HALT / STEP / RUN / BREAK sequencer driving core cpu_en
// Rev 1.0
// ============================================================================
module cpu_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int RUN_DIV    = 25_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_key_step_n,
  input  logic             i_sw_run,
  input  logic             i_sw_bp_en,
  input  logic [3:0]       i_bp_type,
  input  logic [3:0]       i_instr_type,
  input  logic [31:0]      i_pc,
  output logic             o_cpu_en,
  output logic [1:0]       o_ctrl_state,
  output logic [31:0]      o_bp_pc,
  output logic [CNT_W-1:0] o_step_count
);

  localparam int c_div_w = $clog2(RUN_DIV);

  logic               r_run_meta, r_run_sync;
  logic               r_bp_meta, r_bp_sync;
  ctrl_state_t        r_state;
  logic               r_cpu_en;
  logic [c_div_w-1:0] r_div;
  logic [31:0]        r_bp_pc;
  logic [CNT_W-1:0]   r_step_count;
  logic               w_press;
  logic               w_tick;
  logic               w_hit;

  button_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (i_key_step_n),
    .o_press (w_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
      r_bp_meta  <= 1'b0;
      r_bp_sync  <= 1'b0;
    end else begin
      r_run_meta <= i_sw_run;
      r_run_sync <= r_run_meta;
      r_bp_meta  <= i_sw_bp_en;
      r_bp_sync  <= r_bp_meta;
    end
  end

  assign w_tick = (r_div == c_div_w'(RUN_DIV - 1));
  assign w_hit  = bp_hit(r_bp_sync, i_instr_type, i_bp_type);

  // cpu_en is set on the edge that enters STEP or evaluates a RUN tick, so it
  // is high for exactly one cycle and coincides with ctrl_state==STEP on steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_HALT;
      r_cpu_en <= 1'b0;
      r_div    <= '0;
      r_bp_pc  <= '0;
    end else begin
      r_cpu_en <= 1'b0;
      case (r_state)
        ST_HALT: begin
          if (r_run_sync) begin
            r_state <= ST_RUN;
            r_div   <= '0;
          end else if (w_press) begin
            r_state  <= ST_STEP;
            r_cpu_en <= 1'b1;
          end
        end
        ST_STEP: begin
          r_state <= r_run_sync ? ST_RUN : ST_HALT;
          r_div   <= '0;
        end
        ST_RUN: begin
          if (!r_run_sync) begin
            r_state <= ST_HALT;
            r_div   <= '0;
          end else if (w_tick) begin
            r_div <= '0;
            if (w_hit) begin
              r_state <= ST_BREAK;
              r_bp_pc <= i_pc;
            end else begin
              r_cpu_en <= 1'b1;
            end
          end else begin
            r_div <= r_div + c_div_w'(1);
          end
        end
        ST_BREAK: begin
          if (!r_run_sync) begin
            r_state <= ST_HALT;
          end else if (w_press) begin
            r_state  <= ST_STEP;
            r_cpu_en <= 1'b1;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_count <= '0;
    end else if (r_cpu_en) begin
      r_step_count <= r_step_count + CNT_W'(1);
    end
  end

  assign o_cpu_en     = r_cpu_en;
  assign o_ctrl_state = r_state;
  assign o_bp_pc      = r_bp_pc;
  assign o_step_count = r_step_count;

endmodule
`default_nettype wire
